// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst splitter.
// Burst encodings, AXI boundary limits and FSM states.
package dma_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE
  } state_e;

  localparam int AXI_BOUNDARY    = 4096;
  localparam int FIXED_MAX_BEATS = 16;

endpackage

// File: rtl/dma_boundary_room.sv
// Beats of a given size that fit before the next 4 KB boundary.
// Address is assumed aligned to the beat size.
module dma_boundary_room
  import dma_pkg::*;
(
  input  logic [11:0] addr,
  input  logic [2:0]  size,
  output logic [12:0] room
);

  logic [12:0] bytes;

  assign bytes = 13'(AXI_BOUNDARY) - {1'b0, addr};
  assign room  = bytes >> size;

endmodule

// File: rtl/dma_burst_splitter.sv
// Splits DMA copy commands into AXI-legal bursts.
// All outputs registered; CALC sizes a burst, ISSUE hands it off.
module dma_burst_splitter
  import dma_pkg::*;
#(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 32,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [ADDR_WD-1:0] cmd_src_addr,
  input  logic [ADDR_WD-1:0] cmd_dst_addr,
  input  logic [1:0]         cmd_burst,
  input  logic [ADDR_WD-1:0] cmd_len,
  input  logic [2:0]         cmd_size,
  output logic               cmd_ready,
  output logic               cmd_err,
  output logic               bst_valid,
  input  logic               bst_ready,
  output logic [ADDR_WD-1:0] bst_src_addr,
  output logic [ADDR_WD-1:0] bst_dst_addr,
  output logic [7:0]         bst_len,
  output logic [2:0]         bst_size,
  output logic [1:0]         bst_burst,
  output logic               bst_last,
  output logic               done
);

  localparam int DATA_WD_BYTE = DATA_WD / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WD_BYTE));
  localparam int FIX_LIM =
    (MAX_BURST < FIXED_MAX_BEATS) ? MAX_BURST : FIXED_MAX_BEATS;

  state_e             state_q, state_d;
  logic [ADDR_WD-1:0] src_q, src_d;
  logic [ADDR_WD-1:0] dst_q, dst_d;
  logic [ADDR_WD-1:0] rem_q, rem_d;
  logic [2:0]         size_q, size_d;
  logic [1:0]         burst_q, burst_d;
  logic [8:0]         beats_q, beats_d;

  logic               cmd_ready_d, cmd_err_d, done_d;
  logic               bst_valid_d, bst_last_d;
  logic [ADDR_WD-1:0] bst_src_d, bst_dst_d;
  logic [7:0]         bst_len_d;
  logic [2:0]         bst_size_d;
  logic [1:0]         bst_burst_d;

  logic [12:0]        src_room, dst_room, cap;
  logic [8:0]         beats_c;
  logic [ADDR_WD-1:0] amask;
  logic               cmd_bad;

  dma_boundary_room u_src_room (
    .addr (src_q[11:0]),
    .size (size_q),
    .room (src_room)
  );

  dma_boundary_room u_dst_room (
    .addr (dst_q[11:0]),
    .size (size_q),
    .room (dst_room)
  );

  // WRAP and reserved both have bit 1 set
  assign amask   = ~({ADDR_WD{1'b1}} << cmd_size);
  assign cmd_bad = cmd_burst[1]
                 | (cmd_size > SIZE_MAX)
                 | (|(cmd_src_addr & amask))
                 | (|(cmd_dst_addr & amask));

  always_comb begin
    cap = 13'(MAX_BURST);
    if (burst_q == BURST_FIXED) begin
      cap = 13'(FIX_LIM);
    end else begin
      if (src_room < cap) cap = src_room;
      if (dst_room < cap) cap = dst_room;
    end
    beats_c = (rem_q < ADDR_WD'(cap)) ? rem_q[8:0] : cap[8:0];
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beats_d     = beats_q;
    cmd_ready_d = cmd_ready;
    cmd_err_d   = 1'b0;
    done_d      = 1'b0;
    bst_valid_d = bst_valid;
    bst_src_d   = bst_src_addr;
    bst_dst_d   = bst_dst_addr;
    bst_len_d   = bst_len;
    bst_size_d  = bst_size;
    bst_burst_d = bst_burst;
    bst_last_d  = bst_last;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          src_d       = cmd_src_addr;
          dst_d       = cmd_dst_addr;
          rem_d       = cmd_len;
          size_d      = cmd_size;
          burst_d     = cmd_burst;
          unique case (1'b1)
            cmd_bad:         cmd_err_d = 1'b1;
            (cmd_len == '0): done_d    = 1'b1;
            default:         state_d   = S_CALC;
          endcase
        end
      end
      S_CALC: begin
        beats_d     = beats_c;
        bst_src_d   = src_q;
        bst_dst_d   = dst_q;
        bst_len_d   = 8'(beats_c - 9'd1);
        bst_size_d  = size_q;
        bst_burst_d = burst_q;
        bst_last_d  = (ADDR_WD'(beats_c) == rem_q);
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (!bst_valid) begin
          bst_valid_d = 1'b1;
        end else if (bst_ready) begin
          bst_valid_d = 1'b0;
          rem_d       = rem_q - ADDR_WD'(beats_q);
          if (burst_q == BURST_INCR) begin
            src_d = src_q + (ADDR_WD'(beats_q) << size_q);
            dst_d = dst_q + (ADDR_WD'(beats_q) << size_q);
          end
          if (rem_d == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beats_q      <= '0;
      cmd_ready    <= 1'b0;
      cmd_err      <= 1'b0;
      done         <= 1'b0;
      bst_valid    <= 1'b0;
      bst_src_addr <= '0;
      bst_dst_addr <= '0;
      bst_len      <= '0;
      bst_size     <= '0;
      bst_burst    <= '0;
      bst_last     <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beats_q      <= beats_d;
      cmd_ready    <= cmd_ready_d;
      cmd_err      <= cmd_err_d;
      done         <= done_d;
      bst_valid    <= bst_valid_d;
      bst_src_addr <= bst_src_d;
      bst_dst_addr <= bst_dst_d;
      bst_len      <= bst_len_d;
      bst_size     <= bst_size_d;
      bst_burst    <= bst_burst_d;
      bst_last     <= bst_last_d;
    end
  end

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Scoreboard bench for dma_burst_splitter.
// Directed commands push expected bursts; a monitor pops on handshake.
module tb_dma_burst_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_src_addr = '0;
  logic [31:0] cmd_dst_addr = '0;
  logic [1:0]  cmd_burst = '0;
  logic [31:0] cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic        cmd_ready, cmd_err;
  logic        bst_valid;
  logic        bst_ready = 1'b1;
  logic [31:0] bst_src_addr, bst_dst_addr;
  logic [7:0]  bst_len;
  logic [2:0]  bst_size;
  logic [1:0]  bst_burst;
  logic        bst_last, done;

  dma_burst_splitter #(
    .ADDR_WD   (32),
    .DATA_WD   (32),
    .MAX_BURST (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_src_addr (cmd_src_addr),
    .cmd_dst_addr (cmd_dst_addr),
    .cmd_burst    (cmd_burst),
    .cmd_len      (cmd_len),
    .cmd_size     (cmd_size),
    .cmd_ready    (cmd_ready),
    .cmd_err      (cmd_err),
    .bst_valid    (bst_valid),
    .bst_ready    (bst_ready),
    .bst_src_addr (bst_src_addr),
    .bst_dst_addr (bst_dst_addr),
    .bst_len      (bst_len),
    .bst_size     (bst_size),
    .bst_burst    (bst_burst),
    .bst_last     (bst_last),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
    logic        last;
    logic [1:0]  burst;
    logic [2:0]  size;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d,
                      input logic [7:0] l, input logic lst,
                      input logic [1:0] b, input logic [2:0] sz);
    exp_t e;
    e.src = s; e.dst = d; e.len = l;
    e.last = lst; e.burst = b; e.size = sz;
    expq.push_back(e);
  endtask

  // monitor: handshake scoreboard plus hold-until-ready check
  logic        pend = 1'b0;
  logic [31:0] h_src, h_dst;
  logic [7:0]  h_len;
  logic        h_last;

  always @(negedge clk) begin
    if (!rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_valid", bst_valid, 1);
        chk("hold_src", bst_src_addr, h_src);
        chk("hold_dst", bst_dst_addr, h_dst);
        chk("hold_len", bst_len, h_len);
        chk("hold_last", bst_last, h_last);
      end
      if (bst_valid && bst_ready) begin
        hs_cnt++;
        if (expq.size() == 0) begin
          chk("unexpected_burst", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("bst_src", bst_src_addr, e.src);
          chk("bst_dst", bst_dst_addr, e.dst);
          chk("bst_len", bst_len, e.len);
          chk("bst_last", bst_last, e.last);
          chk("bst_burst", bst_burst, e.burst);
          chk("bst_size", bst_size, e.size);
        end
      end
      pend   = bst_valid && !bst_ready;
      h_src  = bst_src_addr;
      h_dst  = bst_dst_addr;
      h_len  = bst_len;
      h_last = bst_last;
      if (done) done_cnt++;
      if (cmd_err) err_cnt++;
    end
  end

  task automatic send_cmd(input logic [31:0] s, input logic [31:0] d,
                          input logic [1:0] b, input logic [31:0] l,
                          input logic [2:0] sz);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    chk("cmd_ready_wait", ok, 1);
    if (ok) begin
      cmd_valid    = 1'b1;
      cmd_src_addr = s;
      cmd_dst_addr = d;
      cmd_burst    = b;
      cmd_len      = l;
      cmd_size     = sz;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({name, "_done"}, got, 1);
    chk({name, "_valid_at_done"}, bst_valid, 0);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, done, 0);
    chk({name, "_queue_empty"}, expq.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bst_valid) begin
        got = 1;
        break;
      end
    end
    chk({name, "_valid_seen"}, got, 1);
  endtask

  task automatic reject(input string name, input logic [31:0] s,
                        input logic [1:0] b, input logic [2:0] sz);
    int e0;
    e0 = err_cnt;
    send_cmd(s, 32'h100, b, 32'd4, sz);
    @(negedge clk);
    chk({name, "_err"}, cmd_err, 1);
    chk({name, "_ready_low"}, cmd_ready, 0);
    chk({name, "_no_valid"}, bst_valid, 0);
    @(negedge clk);
    chk({name, "_err_clr"}, cmd_err, 0);
    chk({name, "_ready_back"}, cmd_ready, 1);
    chk({name, "_no_valid2"}, bst_valid, 0);
    chk({name, "_err_count"}, err_cnt - e0, 1);
  endtask

  function automatic logic any_out();
    return |{cmd_ready, cmd_err, bst_valid, bst_src_addr, bst_dst_addr,
             bst_len, bst_size, bst_burst, bst_last, done};
  endfunction

  initial begin
    int d0, h0;
    // reset state and cmd_ready rising on the first edge after release
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_zero", any_out(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", cmd_ready, 1);

    // INCR split by MAX_BURST, with latency check
    push(32'd128, 32'd512, 8'd15, 1'b0, 2'd1, 3'd2);
    push(32'd192, 32'd576, 8'd15, 1'b1, 2'd1, 3'd2);
    d0 = done_cnt;
    send_cmd(32'd128, 32'd512, 2'd1, 32'd32, 3'd2);
    @(posedge clk);
    #1 chk("lat_t1_valid", bst_valid, 0);
    @(posedge clk);
    #1 chk("lat_t2_valid", bst_valid, 1);
    wait_done("incr32");
    chk("incr32_done_count", done_cnt - d0, 1);

    // INCR split at 4 KB boundary on the source
    push(32'hFF0, 32'h2000, 8'd3, 1'b0, 2'd1, 3'd2);
    push(32'h1000, 32'h2010, 8'd3, 1'b1, 2'd1, 3'd2);
    send_cmd(32'hFF0, 32'h2000, 2'd1, 32'd8, 3'd2);
    wait_done("incr4k");

    // FIXED capped at 16 beats, addresses constant
    push(32'd340, 32'd124, 8'd15, 1'b0, 2'd0, 3'd2);
    push(32'd340, 32'd124, 8'd15, 1'b0, 2'd0, 3'd2);
    push(32'd340, 32'd124, 8'd7, 1'b1, 2'd0, 3'd2);
    send_cmd(32'd340, 32'd124, 2'd0, 32'd40, 3'd2);
    wait_done("fixed40");

    // rejections
    reject("rej_align", 32'd341, 2'd1, 3'd2);
    reject("rej_wrap", 32'd0, 2'd2, 3'd2);
    reject("rej_size", 32'd0, 2'd1, 3'd3);

    // backpressure: hold burst while bst_ready low
    bst_ready = 1'b0;
    h0 = hs_cnt;
    push(32'h0, 32'h100, 8'd3, 1'b1, 2'd1, 3'd2);
    send_cmd(32'h0, 32'h100, 2'd1, 32'd4, 3'd2);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", bst_valid, 1);
      chk("bp_len", bst_len, 8'd3);
      chk("bp_dst", bst_dst_addr, 32'h100);
    end
    @(posedge clk);
    #1 bst_ready = 1'b1;
    wait_done("bp");
    chk("bp_one_burst", hs_cnt - h0, 1);

    // zero length: done only
    h0 = hs_cnt;
    send_cmd(32'h40, 32'h80, 2'd1, 32'd0, 3'd2);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_err", cmd_err, 0);
    chk("len0_valid", bst_valid, 0);
    @(negedge clk);
    chk("len0_done_clr", done, 0);
    chk("len0_no_burst", hs_cnt - h0, 0);

    // reset while a burst is pending
    bst_ready = 1'b0;
    d0 = done_cnt;
    send_cmd(32'h0, 32'h0, 2'd1, 32'd8, 3'd2);
    wait_valid("rst_mid");
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_mid_outs_zero", any_out(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bst_ready = 1'b1;
    h0 = hs_cnt;
    push(32'h40, 32'h80, 8'd3, 1'b1, 2'd1, 3'd2);
    send_cmd(32'h40, 32'h80, 2'd1, 32'd4, 3'd2);
    wait_done("post_rst");
    chk("post_rst_one_burst", hs_cnt - h0, 1);
    chk("post_rst_done_count", done_cnt - d0, 1);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
